// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: activation mode encodings and
// the signed saturation bounds used when narrowing lane results.
package cnn_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_LEAKY  = 2'd2,
        MODE_CLIP   = 2'd3
    } act_mode_e;

    // Largest value representable in a w-bit two's complement number.
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit two's complement number.
    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/act_lane.sv
// One activation lane: applies the selected activation, requantises by an
// arithmetic right shift and saturates the result to OUT_W bits.
module act_lane
    import cnn_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int LEAK_SHIFT = 3,
    parameter int OUT_SHIFT  = 0
) (
    input  act_mode_e                mode,
    input  logic signed [IN_W-1:0]   x,
    input  logic signed [IN_W-1:0]   clip_val,
    output logic signed [OUT_W-1:0]  y,
    output logic                     sat
);

    localparam logic signed [63:0] MAX_V = sat_max(OUT_W);
    localparam logic signed [63:0] MIN_V = sat_min(OUT_W);

    logic signed [IN_W-1:0] act;
    logic signed [IN_W-1:0] z;
    logic signed [63:0]     z_ext;

    // Activation, requantising shift and saturation, all purely combinational.
    always_comb begin
        act = x;
        case (mode)
            MODE_RELU: begin
                if (x[IN_W-1]) act = '0;
            end
            MODE_LEAKY: begin
                if (x[IN_W-1]) act = x >>> LEAK_SHIFT;
            end
            MODE_CLIP: begin
                if (x[IN_W-1]) begin
                    act = '0;
                end else if (x > clip_val) begin
                    act = clip_val;
                end
            end
            default: act = x;
        endcase

        z     = act >>> OUT_SHIFT;
        z_ext = {{(64-IN_W){z[IN_W-1]}}, z};

        y   = z[OUT_W-1:0];
        sat = 1'b0;
        if (z_ext > MAX_V) begin
            y   = MAX_V[OUT_W-1:0];
            sat = 1'b1;
        end else if (z_ext < MIN_V) begin
            y   = MIN_V[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/act_unit_mc.sv
// Multi-lane activation stage: a two-stage stallable valid/ready pipeline.
// Stage 1 captures the beat with its mode and clip value; stage 2 holds the
// activated, requantised and saturated lanes. A saturating counter tracks
// output beats in which any lane saturated.
module act_unit_mc
    import cnn_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int CH         = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int OUT_SHIFT  = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [IN_W-1:0]       clip_val,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*IN_W-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   out_data,
    output logic [CH-1:0]         out_sat,
    input  logic                  sat_clr,
    output logic [CNT_W-1:0]      sat_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 s1_valid_q, s1_valid_d;
    logic [CH*IN_W-1:0]   s1_data_q,  s1_data_d;
    act_mode_e            s1_mode_q,  s1_mode_d;
    logic [IN_W-1:0]      s1_clip_q,  s1_clip_d;
    logic                 out_valid_q, out_valid_d;
    logic [CH*OUT_W-1:0]  out_data_q,  out_data_d;
    logic [CH-1:0]        out_sat_q,   out_sat_d;
    logic [CNT_W-1:0]     sat_cnt_q,   sat_cnt_d;

    logic [CH*OUT_W-1:0]  lane_y;
    logic [CH-1:0]        lane_sat;
    logic                 adv_s2;
    logic                 adv_s1;

    assign adv_s2   = !out_valid_q || out_ready;
    assign adv_s1   = !s1_valid_q || adv_s2;
    assign in_ready = adv_s1;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = sat_cnt_q;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        act_lane #(
            .IN_W       (IN_W),
            .OUT_W      (OUT_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .OUT_SHIFT  (OUT_SHIFT)
        ) u_lane (
            .mode     (s1_mode_q),
            .x        (s1_data_q[g*IN_W +: IN_W]),
            .clip_val (s1_clip_q),
            .y        (lane_y[g*OUT_W +: OUT_W]),
            .sat      (lane_sat[g])
        );
    end

    // Pipeline advance: each stage loads when it is empty or the stage after it moves.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        s1_clip_d   = s1_clip_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (adv_s1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = act_mode_e'(mode);
                s1_clip_d = clip_val;
            end
        end

        if (adv_s2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = lane_y;
                out_sat_d  = lane_sat;
            end
        end
    end

    // Saturation event counter: clear wins, otherwise count saturated transfers without wrapping.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && out_ready && (|out_sat_q) && (sat_cnt_q != CNT_MAX)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; a reset drops any in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= MODE_BYPASS;
            s1_clip_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            sat_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            s1_clip_q   <= s1_clip_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

endmodule
